reduce_gate_sweep: RTL and testbench
====================================

// Module: reduce_gate_sweep
// PURPOSE
//  Parametrised WIDTH-input logic reduction gate (NAND/NOR/AND/OR/XOR/XNOR) with registered output and a
//  valid/ready input path. Built-in exhaustive sweep engine walks all 2^WIDTH input patterns and counts ones
//  on the output. Replaces the fixed 4-input NAND and its external counting stimulus with one self-checking block.
// PARAMETERS
//  WIDTH     4  reduction input count, legal 2..12
//  STEP_CYC  1  cycles each sweep pattern is held, legal 1..255
// PORTS
//  clk          in   1        clock, rising edge
//  rst_n        in   1        synchronous reset, active-low
//  mode         in   3        000 NAND, 001 NOR, 010 AND, 011 OR, 100 XOR, 101 XNOR, 11x -> NAND
//  in_valid     in   1        direct-path input valid
//  in_data      in   WIDTH    direct-path operand
//  in_ready     out  1        direct path accepting
//  out_valid    out  1        out_y valid, 1-cycle pulse per result
//  out_y        out  1        registered reduction result
//  sweep_start  in   1        start exhaustive sweep, sampled in IDLE only
//  sweep_busy   out  1        high in SWEEP
//  sweep_done   out  1        1-cycle pulse in DONE
//  sweep_pat    out  WIDTH    pattern currently applied in sweep
//  ones_cnt     out  WIDTH+1  count of out_y==1 results in current/last sweep
//  sig          out  16       sweep signature (only with REDUCE_SIG_EN)
// BEHAVIOUR
//  - clk is the only clock; rst_n is synchronous and active-low. All state updates on rising clk.
//  - Reset (rst_n=0 at edge, any state incl. mid-sweep): state=IDLE; out_valid, out_y, sweep_busy, sweep_done,
//    sweep_pat, ones_cnt, sig = 0. Partial sweep is discarded.
//  - FSM: IDLE -> SWEEP on sweep_start; SWEEP -> DONE after last pattern's last step cycle; DONE -> IDLE
//    unconditionally after 1 cycle.
//  - in_ready = (state==IDLE) && !sweep_start (combinational). If sweep_start and in_valid coincide in IDLE,
//    sweep wins and no direct transfer occurs.
//  - Direct path: on in_valid&&in_ready, out_y <= f(mode,in_data), out_valid=1 next cycle only. Latency 1.
//  - Sweep start: mode latched into mode_q (sweep ignores mode changes until return to IDLE); ones_cnt,
//    sig, sweep_pat, step counter cleared.
//  - SWEEP: sweep_pat holds each value for STEP_CYC cycles, 0 -> 2^WIDTH-1, incrementing by 1. On the last
//    cycle of each pattern's step, out_y <= f(mode_q,sweep_pat), out_valid=1 next cycle; ones_cnt += that
//    result in the same update. One out_valid per pattern; 2^WIDTH pulses total.
//  - SWEEP occupies exactly 2^WIDTH*STEP_CYC cycles; DONE cycle carries the final out_valid and final
//    ones_cnt; sweep_done=1 in DONE only.
//  - ones_cnt width WIDTH+1 holds 2^WIDTH without overflow; holds value after DONE until next sweep_start.
//  - sweep_pat does not wrap: stops at 2^WIDTH-1 and holds in DONE/IDLE until next start or reset.
//  - sweep_start during SWEEP/DONE ignored; in_valid during SWEEP/DONE ignored (in_ready=0).
//  - Between results out_valid=0; out_y holds last value.
// CONFIGURATION
//  REDUCE_SIG_EN defined: port sig present; on each sweep result sig <= {sig[14:0], sig[15]^sig[13]^sig[12]^
//   sig[10]^out_y_next}; cleared at sweep_start and reset; direct-path results do not touch sig.
//  REDUCE_SIG_EN undefined: no sig port, no signature logic; all other behaviour identical.
// TESTING
//  1. WIDTH=4, mode=NAND, direct in_data=4'hF then 4'h7 -> out_y=0 then 1, each one cycle after accept.
//  2. WIDTH=4, STEP_CYC=1, sweeps NAND/NOR/AND/OR/XOR/XNOR -> ones_cnt=15/1/1/15/8/8; 16 out_valid pulses;
//     sweep_done 17 cycles after the start edge.
//  3. WIDTH=8, STEP_CYC=3, mode=XOR -> ones_cnt=128, 768 SWEEP cycles, mode change mid-sweep has no effect.
//  4. rst_n=0 at pattern 5 of WIDTH=4 sweep -> next cycle IDLE, all outputs 0; new start gives full 15 (NAND).
//  5. sweep_start and in_valid same IDLE cycle -> in_ready=0, sweep runs; in_valid during sweep produces no
//     extra out_valid; sweep_start during SWEEP ignored (still 16 pulses).
//  6. REDUCE_SIG_EN, WIDTH=4, each mode -> sig equals model value; two identical sweeps give identical sig.

Source files
------------

// File: rtl/reduce_if.sv
// Handshake bundle for reduce_gate_sweep.
// REDUCE_SIG_EN adds the 16-bit sweep signature.
interface reduce_if #(
  parameter int WIDTH = 4
);
  logic [2:0]       mode;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_y;
  logic             sweep_start;
  logic             sweep_busy;
  logic             sweep_done;
  logic [WIDTH-1:0] sweep_pat;
  logic [WIDTH:0]   ones_cnt;
`ifdef REDUCE_SIG_EN
  logic [15:0]      sig;

  modport master (
    output mode, in_valid, in_data, sweep_start,
    input  in_ready, out_valid, out_y,
    input  sweep_busy, sweep_done, sweep_pat,
    input  ones_cnt, sig
  );

  modport slave (
    input  mode, in_valid, in_data, sweep_start,
    output in_ready, out_valid, out_y,
    output sweep_busy, sweep_done, sweep_pat,
    output ones_cnt, sig
  );
`else
  modport master (
    output mode, in_valid, in_data, sweep_start,
    input  in_ready, out_valid, out_y,
    input  sweep_busy, sweep_done, sweep_pat,
    input  ones_cnt
  );

  modport slave (
    input  mode, in_valid, in_data, sweep_start,
    output in_ready, out_valid, out_y,
    output sweep_busy, sweep_done, sweep_pat,
    output ones_cnt
  );
`endif
endinterface

// File: rtl/reduce_gate_sweep.sv
// WIDTH-input reduction gate with registered output and exhaustive sweep.
// REDUCE_SIG_EN enables the 16-bit LFSR signature over sweep results.
module reduce_gate_sweep #(
  parameter int WIDTH    = 4,
  parameter int STEP_CYC = 1
) (
  input logic    clk,
  input logic    rst_n,
  reduce_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [2:0]       mode_q;
  logic [7:0]       step_q;
  logic [WIDTH-1:0] pat_q;
  logic [WIDTH:0]   ones_q;
  logic             out_valid_q;
  logic             out_y_q;

  logic accept;
  logic step_last;
  logic pat_last;
  logic fire;
  logic y_next;

  function automatic logic red_f(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] d
  );
    logic r;
    r = ~&d;
    unique case (1'b1)
      (m == 3'b000):      r = ~&d;
      (m == 3'b001):      r = ~|d;
      (m == 3'b010):      r = &d;
      (m == 3'b011):      r = |d;
      (m == 3'b100):      r = ^d;
      (m == 3'b101):      r = ~^d;
      (m[2:1] == 2'b11):  r = ~&d;
    endcase
    return r;
  endfunction

  assign accept    = bus.in_valid && bus.in_ready;
  assign step_last = (step_q == 8'(STEP_CYC - 1));
  assign pat_last  = (pat_q == {WIDTH{1'b1}});
  assign fire      = (state_q == SWEEP) && step_last;
  assign y_next    = red_f(mode_q, pat_q);

  assign bus.in_ready   = (state_q == IDLE) && !bus.sweep_start;
  assign bus.sweep_busy = (state_q == SWEEP);
  assign bus.sweep_done = (state_q == DONE);
  assign bus.sweep_pat  = pat_q;
  assign bus.ones_cnt   = ones_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_y      = out_y_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: DONE lasts exactly one cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.sweep_start) state_d = SWEEP;
      SWEEP:   if (fire && pat_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result register, pattern walk and ones counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_y_q     <= 1'b0;
      mode_q      <= 3'd0;
      step_q      <= 8'd0;
      pat_q       <= '0;
      ones_q      <= '0;
    end else begin
      out_valid_q <= 1'b0;
      if (accept) begin
        out_y_q     <= red_f(bus.mode, bus.in_data);
        out_valid_q <= 1'b1;
      end
      if ((state_q == IDLE) && bus.sweep_start) begin
        mode_q <= bus.mode;
        step_q <= 8'd0;
        pat_q  <= '0;
        ones_q <= '0;
      end
      if (state_q == SWEEP) begin
        if (step_last) begin
          step_q      <= 8'd0;
          out_y_q     <= y_next;
          out_valid_q <= 1'b1;
          ones_q      <= ones_q + {{WIDTH{1'b0}}, y_next};
          if (!pat_last) pat_q <= pat_q + 1'b1;
        end else begin
          step_q <= step_q + 8'd1;
        end
      end
    end
  end

`ifdef REDUCE_SIG_EN
  logic [15:0] sig_q;

  assign bus.sig = sig_q;

  // LFSR signature folds in each sweep result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig_q <= 16'd0;
    end else if ((state_q == IDLE) && bus.sweep_start) begin
      sig_q <= 16'd0;
    end else if (fire) begin
      sig_q <= {sig_q[14:0],
                sig_q[15] ^ sig_q[13] ^ sig_q[12] ^
                sig_q[10] ^ y_next};
    end
  end
`endif

endmodule

// File: tb/tb_reduce_gate_sweep.sv
// Randomized self-checking bench for reduce_gate_sweep.
// Covers WIDTH=4/STEP_CYC=1 and WIDTH=8/STEP_CYC=3.
module tb_reduce_gate_sweep;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  reduce_if #(.WIDTH(4)) b4 ();
  reduce_if #(.WIDTH(8)) b8 ();

  reduce_gate_sweep #(.WIDTH(4), .STEP_CYC(1)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b4)
  );

  reduce_gate_sweep #(.WIDTH(8), .STEP_CYC(3)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b8)
  );

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int f_model(input int m, input int d, input int w);
    int c;
    c = $countones(d & ((1 << w) - 1));
    case (m)
      1:       return (c == 0) ? 1 : 0;
      2:       return (c == w) ? 1 : 0;
      3:       return (c != 0) ? 1 : 0;
      4:       return c % 2;
      5:       return 1 - (c % 2);
      default: return (c != w) ? 1 : 0;
    endcase
  endfunction

  function automatic int ones_model(input int m, input int w);
    int s = 0;
    for (int p = 0; p < (1 << w); p++) s += f_model(m, p, w);
    return s;
  endfunction

  function automatic logic [15:0] sig_model(input int m, input int w);
    logic [15:0] s = 16'd0;
    bit y;
    for (int p = 0; p < (1 << w); p++) begin
      y = (f_model(m, p, w) != 0);
      s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10] ^ y};
    end
    return s;
  endfunction

  task automatic direct4(input int m, input int d);
    @(posedge clk); #1;
    b4.mode     = 3'(m);
    b4.in_data  = 4'(d);
    b4.in_valid = 1'b1;
    @(negedge clk);
    chk("dir_ready", b4.in_ready, 1);
    @(posedge clk); #1;
    b4.in_valid = 1'b0;
    @(negedge clk);
    chk("dir_valid", b4.out_valid, 1);
    chk("dir_y", b4.out_y, f_model(m, d, 4));
    @(negedge clk);
    chk("dir_gap", b4.out_valid, 0);
    chk("dir_hold", b4.out_y, f_model(m, d, 4));
  endtask

  task automatic sweep4(input int m, input bit noise, input bit collide);
    int  pulses = 0;
    int  busy = 0;
    int  done_cyc = 0;
    bit  seen = 0;
    @(posedge clk); #1;
    b4.mode        = 3'(m);
    b4.sweep_start = 1'b1;
    b4.in_valid    = collide;
    b4.in_data     = 4'($urandom);
    @(negedge clk);
    chk("start_ready", b4.in_ready, 0);
    @(posedge clk); #1;
    b4.sweep_start = 1'b0;
    b4.in_valid    = 1'b0;
    for (int cyc = 1; cyc <= 200 && !seen; cyc++) begin
      @(negedge clk);
      if (b4.sweep_busy) begin
        busy++;
        if (noise) chk("busy_ready", b4.in_ready, 0);
      end
      if (b4.out_valid) begin
        chk("sw_y", b4.out_y, f_model(m, pulses, 4));
        pulses++;
      end
      if (b4.sweep_done) begin
        seen = 1;
        done_cyc = cyc;
      end
      if (noise && !seen) begin
        b4.mode        = 3'($urandom);
        b4.in_valid    = 1'($urandom);
        b4.sweep_start = 1'($urandom);
        b4.in_data     = 4'($urandom);
      end else begin
        b4.in_valid    = 1'b0;
        b4.sweep_start = 1'b0;
      end
    end
    chk("sw_done_seen", 32'(seen), 1);
    chk("sw_pulses", pulses, 16);
    chk("sw_busy", busy, 16);
    chk("sw_done_cyc", done_cyc, 17);
    chk("sw_ones", b4.ones_cnt, ones_model(m, 4));
    chk("sw_pat", b4.sweep_pat, 15);
`ifdef REDUCE_SIG_EN
    chk("sw_sig", b4.sig, sig_model(m, 4));
`endif
    @(negedge clk);
    chk("post_done", b4.sweep_done, 0);
    chk("post_valid", b4.out_valid, 0);
    chk("post_ones", b4.ones_cnt, ones_model(m, 4));
    chk("post_ready", b4.in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int busy;
    int bad;
    int done_cyc;
    bit seen;

    b4.mode = 3'd0; b4.in_valid = 1'b0;
    b4.in_data = '0; b4.sweep_start = 1'b0;
    b8.mode = 3'd0; b8.in_valid = 1'b0;
    b8.in_data = '0; b8.sweep_start = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", b4.out_valid, 0);
    chk("rst_y", b4.out_y, 0);
    chk("rst_busy", b4.sweep_busy, 0);
    chk("rst_done", b4.sweep_done, 0);
    chk("rst_pat", b4.sweep_pat, 0);
    chk("rst_ones", b4.ones_cnt, 0);
    chk("rst_ready", b4.in_ready, 1);

    direct4(0, 15);
    direct4(0, 7);
    for (int i = 0; i < 12; i++)
      direct4($urandom_range(0, 7), $urandom_range(0, 15));

    for (int m = 0; m < 6; m++) sweep4(m, 0, 0);
    sweep4(6, 0, 0);
    sweep4(0, 1, 1);
    sweep4(4, 1, 0);
    sweep4(4, 0, 0);

    // reset in the middle of a sweep
    @(posedge clk); #1;
    b4.mode = 3'd0;
    b4.sweep_start = 1'b1;
    @(posedge clk); #1;
    b4.sweep_start = 1'b0;
    seen = 0;
    for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
      @(negedge clk);
      if (b4.sweep_pat == 4'd5) seen = 1;
    end
    chk("mid_pat5", b4.sweep_pat, 5);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_busy", b4.sweep_busy, 0);
    chk("mid_done", b4.sweep_done, 0);
    chk("mid_valid", b4.out_valid, 0);
    chk("mid_y", b4.out_y, 0);
    chk("mid_pat", b4.sweep_pat, 0);
    chk("mid_ones", b4.ones_cnt, 0);
    chk("mid_ready", b4.in_ready, 1);
`ifdef REDUCE_SIG_EN
    chk("mid_sig", b4.sig, 0);
`endif
    sweep4(0, 0, 0);

    // WIDTH=8, STEP_CYC=3, XOR with mode change mid-sweep
    @(posedge clk); #1;
    b8.mode = 3'd4;
    b8.sweep_start = 1'b1;
    @(posedge clk); #1;
    b8.sweep_start = 1'b0;
    pulses = 0; busy = 0; bad = 0; done_cyc = 0; seen = 0;
    for (int cyc = 1; cyc <= 1000 && !seen; cyc++) begin
      @(negedge clk);
      if (b8.sweep_busy) busy++;
      if (b8.out_valid) begin
        if (b8.out_y !== 1'(f_model(4, pulses, 8))) bad++;
        pulses++;
      end
      if (b8.sweep_done) begin
        seen = 1;
        done_cyc = cyc;
      end
      if (cyc == 100) b8.mode = 3'd0;
    end
    chk("w8_done_seen", 32'(seen), 1);
    chk("w8_pulses", pulses, 256);
    chk("w8_busy", busy, 768);
    chk("w8_done_cyc", done_cyc, 769);
    chk("w8_bad_y", bad, 0);
    chk("w8_ones", b8.ones_cnt, ones_model(4, 8));
    chk("w8_ones_const", b8.ones_cnt, 128);
    chk("w8_pat", b8.sweep_pat, 255);
`ifdef REDUCE_SIG_EN
    chk("w8_sig", b8.sig, sig_model(4, 8));
`endif
    @(negedge clk);
    chk("w8_idle", b8.sweep_busy, 0);
    chk("w8_hold", b8.ones_cnt, 128);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
